// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle between an SPI master and the register responder.
interface spi_reg_responder_if;
    logic spi_clk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output spi_clk, output cs, output mosi, input miso);
    modport slave  (input spi_clk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave register file, oversampled in the clk domain.
// Optional SPI_RESP_ID_EN: shift out ID 8'hA5 on miso during the command byte.
module spi_reg_responder #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_reg_responder_if.slave   spi,
    output logic [7:0]           reg0_out,
    output logic                 wr_valid,
    output logic [6:0]           wr_addr,
    output logic [7:0]           wr_data
);

    localparam int unsigned LAST = SYNC_STAGES - 1;
`ifdef SPI_RESP_ID_EN
    localparam logic [7:0] RESP_ID = 8'hA5;
`endif

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_prev, cs_prev;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       rw;
    logic [6:0] addr;
    logic       miso_q;
    logic [7:0] regs [NUM_REGS];

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise_c, sclk_fall_c, cs_fall_c;
    logic [7:0] rx_byte_c;
    logic [6:0] rd_addr_c;
    logic [7:0] rd_val_c;
    logic       mapped_c;
    logic       enter_cmd_c, cmd_done_c, data_done_c, wr_en_c, shift_out_c;

    // Input synchronizers and edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            sclk_prev <= sclk_sync[LAST];
            cs_prev   <= cs_sync[LAST];
        end
    end

    // cs history resets low so a frame already in progress at reset is never picked up mid-way
    assign sclk_s      = sclk_sync[LAST];
    assign cs_s        = cs_sync[LAST];
    assign mosi_s      = mosi_sync[LAST];
    assign sclk_rise_c = sclk_s & ~sclk_prev;
    assign sclk_fall_c = ~sclk_s & sclk_prev;
    assign cs_fall_c   = ~cs_s & cs_prev;
    assign rx_byte_c   = {rx_shift, mosi_s};
    assign mapped_c    = (32'(addr) < NUM_REGS);
    assign rd_addr_c   = cmd_done_c ? rx_byte_c[6:0] : 7'(addr + 7'd1);

    // Register read mux; unmapped addresses read as zero
    always_comb begin
        rd_val_c = 8'h00;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_c == 7'(i)) rd_val_c = regs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and datapath strobes; a completed byte commits even when cs rises alongside it
    always_comb begin
        state_next  = state;
        enter_cmd_c = 1'b0;
        cmd_done_c  = 1'b0;
        data_done_c = 1'b0;
        wr_en_c     = 1'b0;
        shift_out_c = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall_c) begin
                    state_next  = CMD;
                    enter_cmd_c = 1'b1;
                end
            end
            CMD: begin
`ifdef SPI_RESP_ID_EN
                shift_out_c = sclk_fall_c;
`endif
                if (sclk_rise_c && bit_cnt == 3'd7) begin
                    cmd_done_c = 1'b1;
                    state_next = DATA;
                end
                if (cs_s) state_next = IDLE;
            end
            DATA: begin
                shift_out_c = sclk_fall_c;
                if (sclk_rise_c && bit_cnt == 3'd7) begin
                    data_done_c = 1'b1;
                    wr_en_c     = ~rw & mapped_c;
                end
                if (cs_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, address tracking, miso and write-commit outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
            rw       <= 1'b0;
            addr     <= '0;
            miso_q   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= wr_en_c;
            if (wr_en_c) begin
                wr_addr <= addr;
                wr_data <= rx_byte_c;
            end
            if (state_next == IDLE) begin
                miso_q   <= 1'b0;
                tx_shift <= '0;
                bit_cnt  <= '0;
            end else begin
                if (enter_cmd_c) begin
`ifdef SPI_RESP_ID_EN
                    miso_q   <= RESP_ID[7];
                    tx_shift <= {RESP_ID[6:0], 1'b0};
`else
                    miso_q   <= 1'b0;
                    tx_shift <= '0;
`endif
                end
                if (sclk_rise_c && state != IDLE) begin
                    rx_shift <= rx_byte_c[6:0];
                    bit_cnt  <= 3'(bit_cnt + 3'd1);
                end
                if (shift_out_c) begin
                    miso_q   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
                if (cmd_done_c) begin
                    rw       <= rx_byte_c[7];
                    addr     <= rx_byte_c[6:0];
                    tx_shift <= rx_byte_c[7] ? rd_val_c : 8'h00;
                end
                if (data_done_c) begin
                    addr <= 7'(addr + 7'd1);
                    if (rw) tx_shift <= rd_val_c;
                end
            end
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (reset)                             regs[i] <= 8'h00;
            else if (wr_en_c && addr == 7'(i))     regs[i] <= rx_byte_c;
        end
    end

    assign reg0_out = regs[0];
    assign spi.miso = miso_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Scoreboard bench for spi_reg_responder: directed frames plus random frames against a register model.
module tb_spi_reg_responder;

    localparam int unsigned NUM_REGS = 8;
    localparam int          HALF     = 6;
`ifdef SPI_RESP_ID_EN
    localparam logic [7:0] CMD_RESP = 8'hA5;
`else
    localparam logic [7:0] CMD_RESP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] reg0_out;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    spi_reg_responder_if spi ();

    spi_reg_responder #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi      (spi),
        .reg0_out (reg0_out),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [128];
    logic [6:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_rx [$];
    logic [7:0] got_rx [$];
    logic [7:0] fb [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Write-commit monitor
    initial begin
        forever begin
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                if (exp_wa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", wr_addr, wr_data);
                end else begin
                    check("wr_addr", 32'(wr_addr), 32'(exp_wa.pop_front()));
                    check("wr_data", 32'(wr_data), 32'(exp_wd.pop_front()));
                end
            end
        end
    end

    // miso byte monitor
    initial begin
        forever begin
            @(negedge clk);
            while (got_rx.size() > 0) begin
                logic [7:0] g;
                g = got_rx.pop_front();
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL miso_unexpected: got %0h expected nothing", g);
                end else begin
                    check("miso_byte", 32'(g), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            got[7-i] = spi.miso;
            spi.spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.spi_clk = 1'b0;
        end
    endtask

    // Full frame fb[0..n-1]: expectations come from the model before the frame is driven
    task automatic frame(input int n);
        logic [6:0] a;
        logic       rw;
        logic [7:0] g;
        logic [7:0] c;
        c  = fb[0];
        rw = c[7];
        a  = c[6:0];
        exp_rx.push_back(CMD_RESP);
        for (int k = 1; k < n; k++) begin
            if (rw) begin
                exp_rx.push_back((32'(a) < NUM_REGS) ? model[a] : 8'h00);
            end else begin
                exp_rx.push_back(8'h00);
                if (32'(a) < NUM_REGS) begin
                    model[a] = fb[k];
                    exp_wa.push_back(a);
                    exp_wd.push_back(fb[k]);
                end
            end
            a = 7'(a + 7'd1);
        end
        spi.cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            send_bits(fb[k], 8, g);
            got_rx.push_back(g);
        end
        repeat (HALF) @(negedge clk);
        spi.cs = 1'b1;
        repeat (12) @(negedge clk);
        check("reg0_out", 32'(reg0_out), 32'(model[0]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"},     32'(spi.miso), 32'(0));
        check({tag, "_reg0_out"}, 32'(reg0_out), 32'(0));
        check({tag, "_wr_valid"}, 32'(wr_valid), 32'(0));
        check({tag, "_wr_addr"},  32'(wr_addr),  32'(0));
        check({tag, "_wr_data"},  32'(wr_data),  32'(0));
    endtask

    initial begin
        logic [7:0] g;
        logic [6:0] ra;
        int         n;
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        reset       = 1'b1;
        spi.cs      = 1'b1;
        spi.spi_clk = 1'b0;
        spi.mosi    = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write, read back, register 0
        fb[0] = 8'h01; fb[1] = 8'h3C; frame(2);
        fb[0] = 8'h81; fb[1] = 8'h00; frame(2);
        fb[0] = 8'h00; fb[1] = 8'h2A; frame(2);
        fb[0] = 8'h80; fb[1] = 8'h00; frame(2);

        // Burst write past the last mapped register, burst read back
        fb[0] = 8'h06; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33; frame(4);
        fb[0] = 8'h86; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00; frame(4);

        // Abort after a partial byte, then a full write
        spi.cs = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h02, 8, g);
        send_bits(8'hFF, 5, g);
        repeat (HALF) @(negedge clk);
        spi.cs = 1'b1;
        repeat (12) @(negedge clk);
        fb[0] = 8'h82; fb[1] = 8'h00; frame(2);
        fb[0] = 8'h02; fb[1] = 8'h55; frame(2);
        fb[0] = 8'h82; fb[1] = 8'h00; frame(2);

        // Random frames including wrap from 0x7F to 0x00
        for (int r = 0; r < 30; r++) begin
            n  = 2 + int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 7'(124 + $urandom_range(0, 3)) : 7'($urandom_range(0, 11));
            fb[0] = {1'($urandom_range(0, 1)), ra};
            for (int k = 1; k < n; k++) fb[k] = 8'($urandom_range(0, 255));
            frame(n);
        end

        // Make sure reset has something visible to clear
        fb[0] = 8'h00; fb[1] = 8'hC7; fb[2] = 8'h5A; frame(3);

        // Reset in the middle of a data byte; remaining edges with cs low must be ignored
        spi.cs = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h05, 8, g);
        send_bits(8'hC3, 3, g);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("midreset");
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        send_bits(8'hFF, 5, g);
        send_bits(8'h77, 8, g);
        send_bits(8'h01, 8, g);
        repeat (HALF) @(negedge clk);
        spi.cs = 1'b1;
        repeat (12) @(negedge clk);
        fb[0] = 8'h80;
        for (int k = 1; k <= 8; k++) fb[k] = 8'h00;
        frame(9);

        repeat (20) @(negedge clk);
        check("wr_queue_empty",   32'(exp_wa.size()), 32'(0));
        check("miso_queue_empty", 32'(exp_rx.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
